// File: rtl/commit_end_checker.sv
// End-of-test checker for the RV64I core. It watches the commit PC for END_PC and
// enforces a cycle budget. When the end PC commits, it walks a golden table of
// (register, value, enable) entries through the register-file debug port, one entry
// per cycle, and then reports done/pass/timeout together with an error count.
module commit_end_checker #(
    parameter int unsigned          XLEN       = 64,
    parameter int unsigned          NCHK       = 4,
    parameter logic [XLEN-1:0]      END_PC     = 'h1c,
    parameter int unsigned          MAX_CYCLES = 10000,
    localparam int unsigned         IW         = (NCHK > 1) ? $clog2(NCHK) : 1,
    localparam int unsigned         CW         = $clog2(NCHK + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            pc_valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            gold_we_i,
    input  logic [IW-1:0]   gold_idx_i,
    input  logic [4:0]      gold_reg_i,
    input  logic [XLEN-1:0] gold_data_i,
    input  logic            gold_en_i,
    output logic [4:0]      dbg_raddr_o,
    input  logic [XLEN-1:0] dbg_rdata_i,
    output logic            done_o,
    output logic            pass_o,
    output logic            timeout_o,
    output logic [CW-1:0]   err_cnt_o,
    output logic [IW-1:0]   first_err_o,
    output logic [31:0]     cycle_cnt_o
);

    // IDLE only exists for the single cycle between reset release and RUN.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                    state_q;
    logic [IW-1:0]             ptr_q;
    logic [31:0]               cycle_cnt_q;
    logic [31:0]               cycle_cnt_d;
    logic [CW-1:0]             err_cnt_q;
    logic [CW-1:0]             err_cnt_d;
    logic [IW-1:0]             first_err_q;
    logic                      done_q;
    logic                      pass_q;
    logic                      timeout_q;

    logic [NCHK-1:0][4:0]      tbl_reg_q;
    logic [NCHK-1:0][XLEN-1:0] tbl_data_q;
    logic [NCHK-1:0]           tbl_en_q;

    logic                      end_hit;
    logic                      budget_out;
    logic                      last_ent;
    logic                      cur_mis;

    // Golden table: cleared on reset, writable only while the program is running so
    // the table cannot change underneath an in-progress check.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tbl_reg_q  <= '0;
            tbl_data_q <= '0;
            tbl_en_q   <= '0;
        end else if (gold_we_i && (state_q == S_RUN) && (int'(gold_idx_i) < int'(NCHK))) begin
            tbl_reg_q[gold_idx_i]  <= gold_reg_i;
            tbl_data_q[gold_idx_i] <= gold_data_i;
            tbl_en_q[gold_idx_i]   <= gold_en_i;
        end
    end

    // The debug read address must be combinational from ptr: the register file
    // answers in the same cycle and the comparison happens in that cycle too.
    always_comb begin
        dbg_raddr_o = 5'd0;
        if (state_q == S_CHECK) dbg_raddr_o = tbl_reg_q[ptr_q];
    end

    // Per-cycle decode of end detection, budget exhaustion and the current compare.
    always_comb begin
        end_hit     = pc_valid_i && (pc_i == END_PC);
        budget_out  = (cycle_cnt_q == 32'(MAX_CYCLES - 1));
        last_ent    = (ptr_q == IW'(NCHK - 1));
        cur_mis     = (state_q == S_CHECK) && tbl_en_q[ptr_q] &&
                      (dbg_rdata_i != tbl_data_q[ptr_q]);
        err_cnt_d   = err_cnt_q + CW'(cur_mis);
        cycle_cnt_d = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    end

    // Main FSM with registered status outputs; everything freezes once DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cycle_cnt_q <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    cycle_cnt_q <= cycle_cnt_d;
                    // End match takes priority over a budget expiring on the same edge.
                    if (end_hit) begin
                        state_q <= S_CHECK;
                        ptr_q   <= '0;
                    end else if (budget_out) begin
                        state_q   <= S_DONE;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                    end
                end
                S_CHECK: begin
                    err_cnt_q <= err_cnt_d;
                    if (cur_mis && (err_cnt_q == '0)) first_err_q <= ptr_q;
                    if (last_ent) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                    end else begin
                        ptr_q <= ptr_q + IW'(1);
                    end
                end
                default: begin
                    state_q <= S_DONE;
                end
            endcase
        end
    end

    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign err_cnt_o   = err_cnt_q;
    assign first_err_o = first_err_q;
    assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_commit_end_checker.sv
// Directed bench for commit_end_checker: a table of golden-table scenarios with
// hand-computed results, plus hand sequences for timeout, end/timeout tie,
// reset during CHECK and table writes during CHECK.
module tb_commit_end_checker;

    localparam int NCHK = 4;
    localparam logic [63:0] ENDPC = 64'h1c;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_valid;
    logic [63:0] pc;
    logic        gold_we;
    logic [1:0]  gold_idx;
    logic [4:0]  gold_reg;
    logic [63:0] gold_data;
    logic        gold_en;
    logic [4:0]  dbg_raddr;
    logic [63:0] dbg_rdata;
    logic        done, pass, timeout;
    logic [2:0]  err_cnt;
    logic [1:0]  first_err;
    logic [31:0] cycle_cnt;

    logic [63:0] rf [32];
    assign dbg_rdata = rf[dbg_raddr];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    commit_end_checker dut (
        .clk_i(clk), .rst_ni(rst_n), .pc_valid_i(pc_valid), .pc_i(pc),
        .gold_we_i(gold_we), .gold_idx_i(gold_idx), .gold_reg_i(gold_reg),
        .gold_data_i(gold_data), .gold_en_i(gold_en), .dbg_raddr_o(dbg_raddr),
        .dbg_rdata_i(dbg_rdata), .done_o(done), .pass_o(pass), .timeout_o(timeout),
        .err_cnt_o(err_cnt), .first_err_o(first_err), .cycle_cnt_o(cycle_cnt)
    );

    typedef struct {
        logic [3:0][4:0]  r;
        logic [3:0][63:0] d;
        logic [3:0]       en;
        logic [3:0][63:0] rv;
        int               commit_at;
        int               exp_err;
        int               exp_first;
        bit               exp_pass;
    } vec_t;

    vec_t vec [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".done"}, 64'(done), 0);
        chk({nm, ".pass"}, 64'(pass), 0);
        chk({nm, ".timeout"}, 64'(timeout), 0);
        chk({nm, ".err_cnt"}, 64'(err_cnt), 0);
        chk({nm, ".first_err"}, 64'(first_err), 0);
        chk({nm, ".cycle_cnt"}, 64'(cycle_cnt), 0);
        chk({nm, ".dbg_raddr"}, 64'(dbg_raddr), 0);
    endtask

    // Assert reset, check outputs cleared, release; returns in RUN with cycle_cnt=0.
    task automatic do_reset(input string nm);
        rst_n = 1'b0; pc_valid = 1'b0; pc = '0; gold_we = 1'b0;
        gold_idx = '0; gold_reg = '0; gold_data = '0; gold_en = 1'b0;
        #1;
        chk_all_zero({nm, ".rst"});
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wr(input int k, input logic [4:0] r, input logic [63:0] d, input logic en);
        gold_we = 1'b1; gold_idx = 2'(k); gold_reg = r; gold_data = d; gold_en = en;
        step();
        gold_we = 1'b0;
    endtask

    task automatic wait_cnt(input string nm, input int target);
        int g = 0;
        while (cycle_cnt != 32'(target) && g < 11000) begin
            step();
            g++;
        end
        if (cycle_cnt != 32'(target)) begin
            failures++;
            $display("FAIL %s.wait actual=%0d expected=%0d", nm, cycle_cnt, target);
        end
    endtask

    task automatic commit_end();
        pc = ENDPC; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; pc = '0;
    endtask

    task automatic set_ent(input int v, input int k, input logic [4:0] r,
                           input logic [63:0] d, input logic en, input logic [63:0] rv);
        vec[v].r[k] = r; vec[v].d[k] = d; vec[v].en[k] = en; vec[v].rv[k] = rv;
    endtask

    task automatic set_res(input int v, input int at, input int e, input int f, input bit p);
        vec[v].commit_at = at; vec[v].exp_err = e; vec[v].exp_first = f; vec[v].exp_pass = p;
    endtask

    task automatic rf_bg();
        for (int i = 0; i < 32; i++) rf[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    endtask

    initial begin
        // Scenario table: entries k=0..3 as {reg, golden, enable, regfile value}.
        set_ent(0, 0, 5'd3, 64'd0, 1'b1, 64'd0);
        set_ent(0, 1, 5'd0, 64'd0, 1'b0, 64'd0);
        set_ent(0, 2, 5'd0, 64'd0, 1'b0, 64'd0);
        set_ent(0, 3, 5'd0, 64'd0, 1'b0, 64'd0);
        set_res(0, 20, 0, 0, 1'b1);
        set_ent(1, 0, 5'd0, 64'd0, 1'b0, 64'd0);
        set_ent(1, 1, 5'd5, 64'hDEAD, 1'b1, 64'hBEEF);
        set_ent(1, 2, 5'd0, 64'd0, 1'b0, 64'd0);
        set_ent(1, 3, 5'd7, 64'd5, 1'b1, 64'd6);
        set_res(1, 12, 2, 1, 1'b0);
        set_ent(2, 0, 5'd1, 64'hFFFF_0000_1234_5678, 1'b1, 64'hFFFF_0000_1234_5678);
        set_ent(2, 1, 5'd2, 64'd1, 1'b1, 64'd1);
        set_ent(2, 2, 5'd4, 64'd0, 1'b1, 64'd0);
        set_ent(2, 3, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        set_res(2, 8, 0, 0, 1'b1);
        set_ent(3, 0, 5'd1, 64'd5, 1'b1, 64'd5);
        set_ent(3, 1, 5'd2, 64'd6, 1'b1, 64'd6);
        set_ent(3, 2, 5'd3, 64'd7, 1'b1, 64'd7);
        set_ent(3, 3, 5'd4, 64'h8000_0000_0000_0000, 1'b1, 64'd0);
        set_res(3, 9, 1, 3, 1'b0);
        set_ent(4, 0, 5'd10, 64'd1, 1'b1, 64'd2);
        set_ent(4, 1, 5'd11, 64'd1, 1'b1, 64'd3);
        set_ent(4, 2, 5'd12, 64'd1, 1'b1, 64'd4);
        set_ent(4, 3, 5'd13, 64'd1, 1'b1, 64'd5);
        set_res(4, 10, 4, 0, 1'b0);
        set_ent(5, 0, 5'd6, 64'd9, 1'b1, 64'd8);
        set_ent(5, 1, 5'd6, 64'd8, 1'b0, 64'd8);
        set_ent(5, 2, 5'd20, 64'd1, 1'b0, 64'd2);
        set_ent(5, 3, 5'd21, 64'd3, 1'b1, 64'd3);
        set_res(5, 15, 1, 0, 1'b0);

        rf_bg();
        do_reset("init");

        for (int v = 0; v < 6; v++) begin
            string nm;
            nm = $sformatf("v%0d", v);
            rf_bg();
            for (int k = 0; k < NCHK; k++) rf[vec[v].r[k]] = vec[v].rv[k];
            do_reset(nm);
            for (int k = 0; k < NCHK; k++) wr(k, vec[v].r[k], vec[v].d[k], vec[v].en[k]);
            wait_cnt(nm, vec[v].commit_at);
            commit_end();
            chk({nm, ".cnt_at_check"}, 64'(cycle_cnt), 64'(vec[v].commit_at + 1));
            for (int k = 0; k < NCHK; k++) begin
                chk($sformatf("%s.busy%0d", nm, k), 64'(done), 0);
                chk($sformatf("%s.raddr%0d", nm, k), 64'(dbg_raddr), 64'(vec[v].r[k]));
                step();
            end
            chk({nm, ".done"}, 64'(done), 1);
            chk({nm, ".pass"}, 64'(pass), 64'(vec[v].exp_pass));
            chk({nm, ".timeout"}, 64'(timeout), 0);
            chk({nm, ".err_cnt"}, 64'(err_cnt), 64'(vec[v].exp_err));
            if (vec[v].exp_err != 0)
                chk({nm, ".first_err"}, 64'(first_err), 64'(vec[v].exp_first));
            chk({nm, ".raddr_done"}, 64'(dbg_raddr), 0);
            step(); step(); step();
            chk({nm, ".hold_done"}, 64'(done), 1);
            chk({nm, ".hold_cnt"}, 64'(cycle_cnt), 64'(vec[v].commit_at + 1));
        end

        // Timeout: pc_valid never rises.
        rf_bg();
        do_reset("to");
        wait_cnt("to", 9999);
        chk("to.pre_done", 64'(done), 0);
        chk("to.pre_timeout", 64'(timeout), 0);
        step();
        chk("to.done", 64'(done), 1);
        chk("to.timeout", 64'(timeout), 1);
        chk("to.pass", 64'(pass), 0);
        chk("to.raddr", 64'(dbg_raddr), 0);
        chk("to.cnt", 64'(cycle_cnt), 10000);
        step(); step(); step();
        chk("to.cnt_frozen", 64'(cycle_cnt), 10000);
        chk("to.hold_timeout", 64'(timeout), 1);

        // End match on the same edge as the budget expiring: CHECK wins.
        rf_bg(); rf[3] = 64'd0;
        do_reset("tie");
        wr(0, 5'd3, 64'd0, 1'b1);
        wait_cnt("tie", 9999);
        commit_end();
        chk("tie.timeout", 64'(timeout), 0);
        chk("tie.in_check", 64'(done), 0);
        chk("tie.raddr", 64'(dbg_raddr), 3);
        chk("tie.cnt", 64'(cycle_cnt), 10000);
        step(); step(); step(); step();
        chk("tie.done", 64'(done), 1);
        chk("tie.pass", 64'(pass), 1);
        chk("tie.timeout_end", 64'(timeout), 0);

        // Reset in the second CHECK cycle, then an empty-table run.
        rf_bg(); rf[3] = 64'd0; rf[5] = 64'hBEEF;
        do_reset("rc");
        wr(0, 5'd3, 64'd0, 1'b1);
        wr(1, 5'd5, 64'hDEAD, 1'b1);
        wait_cnt("rc", 6);
        commit_end();
        chk("rc.raddr0", 64'(dbg_raddr), 3);
        step();
        chk("rc.raddr1", 64'(dbg_raddr), 5);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rc.async");
        step();
        rst_n = 1'b1;
        step();
        wait_cnt("rc2", 3);
        commit_end();
        step();
        chk("rc2.raddr1", 64'(dbg_raddr), 0);
        step(); step(); step();
        chk("rc2.done", 64'(done), 1);
        chk("rc2.pass", 64'(pass), 1);
        chk("rc2.err_cnt", 64'(err_cnt), 0);

        // End PC without pc_valid is ignored; table writes during CHECK are dropped.
        rf_bg(); rf[9] = 64'h77;
        do_reset("wc");
        wr(2, 5'd9, 64'h77, 1'b1);
        pc = ENDPC; pc_valid = 1'b0;
        step(); step(); step();
        chk("wc.no_end_raddr", 64'(dbg_raddr), 0);
        chk("wc.no_end_cnt", 64'(cycle_cnt), 4);
        chk("wc.no_end_done", 64'(done), 0);
        commit_end();
        gold_we = 1'b1; gold_idx = 2'd2; gold_reg = 5'd9; gold_data = 64'h66; gold_en = 1'b1;
        step();
        gold_idx = 2'd3; gold_data = 64'h1;
        step();
        chk("wc.raddr2", 64'(dbg_raddr), 9);
        gold_we = 1'b0;
        step(); step();
        chk("wc.done", 64'(done), 1);
        chk("wc.pass", 64'(pass), 1);
        chk("wc.err_cnt", 64'(err_cnt), 0);
        chk("wc.cnt", 64'(cycle_cnt), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
